// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the 8-bit ALU datapath.
//   W       operand width
//   CNT_W   iteration counter width (clog2(W))
//   C_*     bit positions of the micro-ops inside the 11-bit control word
//   ovf9    signed 8-bit overflow of a 9-bit sign-extended sum
package alu_pkg;

  localparam int W     = 8;
  localparam int CNT_W = 3;
  localparam int C_W   = 11;

  localparam int C_LDX  = 0;
  localparam int C_LDY  = 1;
  localparam int C_MVA  = 2;
  localparam int C_ADD  = 3;
  localparam int C_SUB  = 4;
  localparam int C_OUTA = 5;
  localparam int C_ASHR = 6;
  localparam int C_CNT  = 7;
  localparam int C_OUTQ = 8;
  localparam int C_SHL  = 9;
  localparam int C_QBIT = 10;

  // Bits 8 and 7 disagree exactly when the signed 8-bit result overflowed.
  function automatic logic ovf9(input logic [8:0] s);
    return s[8] ^ s[7];
  endfunction

endpackage

// File: rtl/alu_datapath_if.sv
// alu_datapath_if: control/data bundle between the ALU control unit (master)
// and the datapath (slave).
//   inbus   operand byte, c   11-bit control word          (master -> slave)
//   outbus  result byte, q0/q_1/a_8/cnt status bits         (slave -> master)
//   ovf     sticky signed overflow, present only with ALU_OVF_EN defined
interface alu_datapath_if;
  import alu_pkg::*;

  logic [W-1:0]     inbus;
  logic [C_W-1:0]   c;
  logic [W-1:0]     outbus;
  logic             q0;
  logic             q_1;
  logic             a_8;
  logic [CNT_W-1:0] cnt;
`ifdef ALU_OVF_EN
  logic             ovf;
`endif

  modport master (
    output inbus, c,
`ifdef ALU_OVF_EN
    input  ovf,
`endif
    input  outbus, q0, q_1, a_8, cnt
  );

  modport slave (
    input  inbus, c,
`ifdef ALU_OVF_EN
    output ovf,
`endif
    output outbus, q0, q_1, a_8, cnt
  );

endinterface

// File: rtl/alu_adder9.sv
// alu_adder9: combinational 9-bit adder/subtractor shared by add, subtract,
// Booth multiply and non-restoring divide.
//   a, b  9-bit operands
//   sub   1 selects a - b (a + ~b + 1), 0 selects a + b
//   sum   9-bit result, modulo 2^9
module alu_adder9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       sub,
  output logic [8:0] sum
);

  logic [8:0] b_eff;

  // Invert b and inject the carry for two's-complement subtraction.
  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = a + b_eff + {8'd0, sub};
  end

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: register/arithmetic datapath of the 8-bit ALU. Executes one
// control word per clock on registers A[8:0], Q[7:0], Q_1, M[7:0], dm, cnt.
//   clk     rising-edge clock
//   rst_b   asynchronous active-low reset, clears every register
//   bus     alu_datapath_if.slave: inbus/c in; outbus, q0, q_1, a_8, cnt out
// Optional: define ALU_OVF_EN to add the sticky signed-overflow output ovf.
module alu_datapath
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_b,
  alu_datapath_if.slave bus
);

  logic [8:0]       a_r, a_nx;
  logic [W-1:0]     q_r, q_nx;
  logic             q1_r, q1_nx;
  logic [W-1:0]     m_r, m_nx;
  logic             dm_r, dm_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [W-1:0]     out_r, out_nx;
  logic [8:0]       mx;
  logic [8:0]       sum;
  logic             sub_op;
  logic [C_W-1:0]   c;

  assign c = bus.c;

  // Divide treats M as unsigned; add/sub/Booth treat it as signed.
  assign mx     = dm_r ? {1'b0, m_r} : {m_r[7], m_r};
  assign sub_op = c[C_ADD] & c[C_SUB];

  alu_adder9 u_adder (
    .a   (a_r),
    .b   (mx),
    .sub (sub_op),
    .sum (sum)
  );

  // Next-state selection; the if-chains encode the write priority between
  // micro-ops that target the same register.
  always_comb begin
    a_nx   = a_r;
    q_nx   = q_r;
    q1_nx  = q1_r;
    m_nx   = m_r;
    dm_nx  = dm_r;
    cnt_nx = cnt_r;
    out_nx = out_r;

    if (c[C_LDX])       a_nx = 9'd0;
    else if (c[C_MVA])  a_nx = {q_r[7], q_r};
    else if (c[C_SHL])  a_nx = {a_r[7:0], q_r[7]};
    else if (c[C_ADD])  a_nx = sum;
    else if (c[C_ASHR]) a_nx = {a_r[8], a_r[8:1]};
    else                a_nx = a_r;

    // Quotient bit looks at the sign of the A being written this cycle.
    if (c[C_LDX])       q_nx = bus.inbus;
    else if (c[C_SHL])  q_nx = {q_r[6:0], 1'b0};
    else if (c[C_ASHR]) q_nx = {a_r[0], q_r[7:1]};
    else if (c[C_QBIT]) q_nx = {q_r[7:1], ~a_nx[8]};
    else                q_nx = q_r;

    if (c[C_LDX])       q1_nx = 1'b0;
    else if (c[C_ASHR]) q1_nx = q_r[0];
    else                q1_nx = q1_r;

    if (c[C_LDY]) m_nx = bus.inbus;
    else          m_nx = m_r;

    if (c[C_LDX])      dm_nx = 1'b0;
    else if (c[C_SHL]) dm_nx = 1'b1;
    else               dm_nx = dm_r;

    if (c[C_LDX])      cnt_nx = {CNT_W{1'b0}};
    else if (c[C_CNT]) cnt_nx = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else               cnt_nx = cnt_r;

    if (c[C_OUTQ])      out_nx = q_r;
    else if (c[C_OUTA]) out_nx = a_r[7:0];
    else                out_nx = out_r;
  end

  // Datapath register bank.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_r   <= 9'd0;
      q_r   <= 8'd0;
      q1_r  <= 1'b0;
      m_r   <= 8'd0;
      dm_r  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
      out_r <= 8'd0;
    end else begin
      a_r   <= a_nx;
      q_r   <= q_nx;
      q1_r  <= q1_nx;
      m_r   <= m_nx;
      dm_r  <= dm_nx;
      cnt_r <= cnt_nx;
      out_r <= out_nx;
    end
  end

  assign bus.outbus = out_r;
  assign bus.q0     = q_r[0];
  assign bus.q_1    = q1_r;
  assign bus.a_8    = a_r[8];
  assign bus.cnt    = cnt_r;

`ifdef ALU_OVF_EN
  logic ovf_r, ovf_nx;

  // Overflow only means something for signed add/sub that is not combined
  // with a shift; once set it stays until the next operand load.
  always_comb begin
    ovf_nx = ovf_r;
    if (c[C_LDX])
      ovf_nx = 1'b0;
    else if (c[C_ADD] && !dm_r && !c[C_ASHR] && !c[C_SHL])
      ovf_nx = ovf_r | ovf9(a_nx);
    else
      ovf_nx = ovf_r;
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ovf_r <= 1'b0;
    else        ovf_r <= ovf_nx;
  end

  assign bus.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed bench for alu_datapath. Result bytes expected
// from each output micro-op are queued when it is issued and popped when
// outbus updates; status bits are compared directly against bench values.
module tb_alu_datapath;
  import alu_pkg::*;

  localparam logic [10:0] K_LDX  = 11'd1 << C_LDX;
  localparam logic [10:0] K_LDY  = 11'd1 << C_LDY;
  localparam logic [10:0] K_MVA  = 11'd1 << C_MVA;
  localparam logic [10:0] K_ADD  = 11'd1 << C_ADD;
  localparam logic [10:0] K_SUB  = 11'd1 << C_SUB;
  localparam logic [10:0] K_OUTA = 11'd1 << C_OUTA;
  localparam logic [10:0] K_ASHR = 11'd1 << C_ASHR;
  localparam logic [10:0] K_CNT  = 11'd1 << C_CNT;
  localparam logic [10:0] K_OUTQ = 11'd1 << C_OUTQ;
  localparam logic [10:0] K_SHL  = 11'd1 << C_SHL;
  localparam logic [10:0] K_QBIT = 11'd1 << C_QBIT;

  logic clk;
  logic rst_b;
  int   vectors;
  int   miscompares;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  alu_datapath_if bus ();

  alu_datapath dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one control word for exactly one rising edge.
  task automatic step(input logic [10:0] cw, input logic [7:0] din);
    @(negedge clk);
    bus.c     = cw;
    bus.inbus = din;
    @(posedge clk);
    #1;
    bus.c     = 11'd0;
  endtask

  // Issue an output micro-op and check the byte it produces.
  task automatic emit(input logic [10:0] cw, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step(cw, 8'd0);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {24'd0, bus.outbus}, {24'd0, e});
  endtask

  task automatic addsub(input logic [7:0] x, input logic [7:0] y, input bit sub,
                        input logic [7:0] exp, input string tag);
    step(K_LDX, x);
    step(K_LDY, y);
    step(K_MVA, 8'd0);
    step(sub ? (K_ADD | K_SUB) : K_ADD, 8'd0);
    emit(K_OUTA, exp, tag);
  endtask

  // Booth radix-2: decisions come from the multiplier bits pairwise.
  task automatic booth(input logic [7:0] x, input logic [7:0] y, input int iters);
    logic prev;
    logic cur;
    step(K_LDX, x);
    step(K_LDY, y);
    prev = 1'b0;
    for (int i = 0; i < iters; i++) begin
      cur = x[i];
      chk("booth_q0", {31'd0, bus.q0}, {31'd0, cur});
      chk("booth_q_1", {31'd0, bus.q_1}, {31'd0, prev});
      if (cur && !prev)      step(K_ADD | K_SUB, 8'd0);
      else if (!cur && prev) step(K_ADD, 8'd0);
      step(K_ASHR | K_CNT, 8'd0);
      prev = cur;
    end
  endtask

  // Non-restoring division driven by a bench-side partial remainder.
  task automatic divide(input logic [7:0] x, input logic [7:0] y);
    int  rem;
    bit  pos;
    logic [7:0] quo_e, rem_e;
    quo_e = (y == 8'd0) ? 8'hFF : x / y;
    rem_e = (y == 8'd0) ? x : x % y;
    step(K_LDX, x);
    step(K_LDY, y);
    rem = 0;
    for (int i = 7; i >= 0; i--) begin
      pos = (rem >= 0);
      chk("div_a_8", {31'd0, bus.a_8}, {31'd0, ~pos});
      step(K_SHL, 8'd0);
      rem = 2 * rem + int'(x[i]);
      step(pos ? (K_ADD | K_SUB | K_QBIT | K_CNT) : (K_ADD | K_QBIT | K_CNT), 8'd0);
      rem = pos ? rem - int'(y) : rem + int'(y);
    end
    if (rem < 0) begin
      step(K_ADD, 8'd0);
      rem = rem + int'(y);
    end
    chk("div_cnt_wrap", {29'd0, bus.cnt}, 32'd0);
    emit(K_OUTA, rem_e, "div_remainder");
    emit(K_OUTQ, quo_e, "div_quotient");
  endtask

  task automatic reset_pulse();
    #2;
    rst_b = 1'b0;
    #1;
  endtask

  initial begin
    logic signed [15:0] prod;
    vectors     = 0;
    miscompares = 0;
    rst_b       = 1'b0;
    bus.c       = 11'd0;
    bus.inbus   = 8'd0;
    #3;
    chk("rst_outbus", {24'd0, bus.outbus}, 32'd0);
    chk("rst_status", {26'd0, bus.q0, bus.q_1, bus.a_8, bus.cnt}, 32'd0);
`ifdef ALU_OVF_EN
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    #9;
    rst_b = 1'b1;

    // Add / subtract
    addsub(8'd100, 8'd27, 1'b0, 8'h7F, "add_100_27");
`ifdef ALU_OVF_EN
    chk("ovf_add_ok", {31'd0, bus.ovf}, 32'd0);
`endif
    addsub(8'd5, 8'd10, 1'b1, 8'hFB, "sub_5_10");
`ifdef ALU_OVF_EN
    chk("ovf_sub_ok", {31'd0, bus.ovf}, 32'd0);
`endif
    addsub(8'd100, 8'd50, 1'b0, 8'h96, "add_100_50");
`ifdef ALU_OVF_EN
    chk("ovf_set", {31'd0, bus.ovf}, 32'd1);
    step(K_MVA, 8'd0);
    chk("ovf_sticky", {31'd0, bus.ovf}, 32'd1);
    step(K_LDX, 8'd0);
    chk("ovf_clear_c0", {31'd0, bus.ovf}, 32'd0);
`endif

    // Booth multiply -3 * 7
    booth(8'hFD, 8'h07, 8);
    chk("booth_cnt_wrap", {29'd0, bus.cnt}, 32'd0);
    prod = $signed(8'hFD) * $signed(8'h07);
    emit(K_OUTA, prod[15:8], "mul_high");
    emit(K_OUTQ, prod[7:0], "mul_low");

    // Divide
    divide(8'd200, 8'd7);
    divide(8'd200, 8'd0);

    // Reset mid-multiply at cnt=3
    booth(8'hFD, 8'h07, 3);
    chk("mid_mul_cnt", {29'd0, bus.cnt}, 32'd3);
    reset_pulse();
    chk("midrst_outbus", {24'd0, bus.outbus}, 32'd0);
    chk("midrst_status", {26'd0, bus.q0, bus.q_1, bus.a_8, bus.cnt}, 32'd0);
    rst_b = 1'b1;
    emit(K_OUTQ, 8'h00, "midrst_q");
    emit(K_OUTA, 8'h00, "midrst_a");
    addsub(8'd1, 8'd1, 1'b0, 8'h02, "add_after_rst");

    // Reset clears dm: M=0xFF must be sign-extended afterwards
    step(K_LDX, 8'h10);
    step(K_LDY, 8'h03);
    step(K_SHL, 8'd0);
    reset_pulse();
    rst_b = 1'b1;
    step(K_LDY, 8'hFF);
    step(K_ADD, 8'd0);
    chk("dm_cleared_a_8", {31'd0, bus.a_8}, 32'd1);
    emit(K_OUTA, 8'hFF, "dm_cleared_a");

    // Priority: c0 beats c6; c8 beats c5
    step(K_LDX, 8'h01);
    step(K_ASHR, 8'd0);
    chk("prio_pre_q_1", {31'd0, bus.q_1}, 32'd1);
    step(K_LDY, 8'h80);
    step(K_ADD, 8'd0);
    chk("prio_pre_a_8", {31'd0, bus.a_8}, 32'd1);
    step(K_LDX | K_ASHR, 8'h5A);
    chk("prio_c0_c6_flags", {29'd0, bus.q0, bus.q_1, bus.a_8}, 32'd0);
    emit(K_OUTA, 8'h00, "prio_c0_c6_a");
    emit(K_OUTQ, 8'h5A, "prio_c0_c6_q");
    step(K_LDY, 8'h03);
    step(K_ADD, 8'd0);
    emit(K_OUTA | K_OUTQ, 8'h5A, "prio_c5_c8");

    // Idle word holds state
    step(11'd0, 8'hAA);
    chk("hold_outbus", {24'd0, bus.outbus}, 32'h5A);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
